// File: rtl/clk_rate_pkg.sv
// ---------------------------------------------------------------------------
// clk_rate_pkg
// Shared definitions for the divided-clock rate controller.
//   - Rate select encodings (RATE_DIV2/4/8, RATE_BAD)
//   - FSM state type for clk_rate_ctrl
//   - tc_of(): terminal count of the 3-bit divider for a given rate select
// ---------------------------------------------------------------------------
package clk_rate_pkg;

    localparam logic [1:0] RATE_DIV2 = 2'd0;
    localparam logic [1:0] RATE_DIV4 = 2'd1;
    localparam logic [1:0] RATE_DIV8 = 2'd2;
    localparam logic [1:0] RATE_BAD  = 2'd3;

    // Longest legal DRAIN: one full /8 period.
    localparam logic [3:0] DRAIN_MAX = 4'd8;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_e;

    function automatic logic [2:0] tc_of(input logic [1:0] sel);
        case (sel)
            RATE_DIV2: tc_of = 3'd1;
            RATE_DIV4: tc_of = 3'd3;
            default:   tc_of = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/clk_rate_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_rate_ctrl_if
// Rate-change handshake and rate outputs of clk_rate_ctrl.
//   req      requester -> ctrl  rate-change request (held until ack/err)
//   sel[1:0] requester -> ctrl  requested rate
//   ack      ctrl -> requester  switch complete / same-rate acknowledge
//   err      ctrl -> requester  request rejected (sel = 3)
//   busy     ctrl -> requester  switch in progress
//   locked   ctrl -> requester  strobe running at a settled rate
//   cur_sel  ctrl -> requester  rate currently in effect
//   rate_stb ctrl -> requester  one-cycle clock-enable strobe
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface clk_rate_ctrl_if;

    logic       req;
    logic [1:0] sel;
    logic       ack;
    logic       err;
    logic       busy;
    logic       locked;
    logic [1:0] cur_sel;
    logic       rate_stb;

    modport master (
        output req, sel,
        input  ack, err, busy, locked, cur_sel, rate_stb
    );

    modport slave (
        input  req, sel,
        output ack, err, busy, locked, cur_sel, rate_stb
    );

endinterface

// File: rtl/clk_rate_div.sv
// ---------------------------------------------------------------------------
// clk_rate_div
// 3-bit rate divider: counts enabled cycles and strobes on terminal count.
//   clk  in   system clock
//   rst  in   synchronous active-high reset (counter -> 0)
//   run  in   count enable (also qualifies the strobe)
//   clr  in   synchronous counter clear, has priority over run
//   sel  in   rate select, terminal count = tc_of(sel)
//   stb  out  high in the cycle the counter sits on terminal count
// ---------------------------------------------------------------------------
module clk_rate_div
    import clk_rate_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] sel,
    output logic       stb
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       at_tc;

    always_comb begin
        at_tc = (cnt_q == tc_of(sel));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 3'd0;
        end else if (run) begin
            cnt_d = at_tc ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stb = run & at_tc;

endmodule

// File: rtl/clk_rate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_rate_ctrl
// Sequences the divided-clock resource: emits rate_stb at clk/2, /4 or /8 and
// switches rate only on strobe boundaries, with a settle gap after each switch.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   enb   in   global enable; low freezes FSM and counters, masks
//              rate_stb/ack/err (a pending ack/err is deferred)
//   bus   slave modport of clk_rate_ctrl_if (req/sel/ack/err/busy/
//              locked/cur_sel/rate_stb)
// Parameters: SETTLE_CYC (1..15) strobe-free cycles after reset/switch,
//             DEF_SEL rate selected out of reset.
// Optional feature, macro CLK_RATE_CTRL_STATS_EN:
//   sw_count[7:0] out  saturating count of completed real switches
//   stb_miss      out  sticky flag, DRAIN lasted longer than one /8 period
// ---------------------------------------------------------------------------
module clk_rate_ctrl
    import clk_rate_pkg::*;
#(
    parameter int         SETTLE_CYC = 4,
    parameter logic [1:0] DEF_SEL    = 2'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enb,
    clk_rate_ctrl_if.slave  bus
`ifdef CLK_RATE_CTRL_STATS_EN
    ,
    output logic [7:0]      sw_count,
    output logic            stb_miss
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e     state_q,    state_d;
    logic [3:0] settle_q,   settle_d;
    logic [1:0] cur_sel_q,  cur_sel_d;
    logic [1:0] pend_sel_q, pend_sel_d;
    logic       busy_q,     busy_d;
    logic       ack_q,      ack_d;
    logic       err_q,      err_d;

    logic       div_run;
    logic       div_clr;
    logic       div_stb;
    logic       req_ok;
    logic       settle_done;

    clk_rate_div u_div (
        .clk (clk),
        .rst (rst),
        .run (div_run),
        .clr (div_clr),
        .sel (cur_sel_q),
        .stb (div_stb)
    );

    // The divider only advances while running at a locked rate or draining.
    assign div_run = enb && ((state_q == RUN) || (state_q == DRAIN));

    // req is still high during the ack/err cycle itself; it must not be taken
    // as a fresh request until the requester has had a chance to drop it.
    assign req_ok = bus.req && !ack_q && !err_q;

    assign settle_done = (state_q == SETTLE) && (settle_q == SETTLE_LAST);

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        busy_d     = busy_q;
        ack_d      = ack_q;
        err_d      = err_q;
        div_clr    = 1'b0;

        if (enb) begin
            ack_d = 1'b0;
            err_d = 1'b0;
            case (state_q)
                SETTLE: begin
                    if (settle_done) begin
                        settle_d = 4'd0;
                        state_d  = RUN;
                        // busy marks a settle that follows a switch; the
                        // post-reset settle completes silently.
                        if (busy_q) begin
                            ack_d  = 1'b1;
                            busy_d = 1'b0;
                        end
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                RUN: begin
                    if (req_ok) begin
                        if (bus.sel == RATE_BAD) begin
                            err_d = 1'b1;
                        end else if (bus.sel == cur_sel_q) begin
                            ack_d = 1'b1;
                        end else begin
                            pend_sel_d = bus.sel;
                            busy_d     = 1'b1;
                            state_d    = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The boundary strobe itself is still delivered.
                    if (div_stb) begin
                        state_d = SWITCH;
                    end
                end
                SWITCH: begin
                    cur_sel_d = pend_sel_q;
                    div_clr   = 1'b1;
                    settle_d  = 4'd0;
                    state_d   = SETTLE;
                end
                default: begin
                    state_d = SETTLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SETTLE;
            settle_q   <= 4'd0;
            cur_sel_q  <= DEF_SEL;
            pend_sel_q <= DEF_SEL;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus.ack      = ack_q & enb;
    assign bus.err      = err_q & enb;
    assign bus.busy     = busy_q;
    assign bus.locked   = (state_q == RUN);
    assign bus.cur_sel  = cur_sel_q;
    assign bus.rate_stb = div_stb;

`ifdef CLK_RATE_CTRL_STATS_EN
    logic [7:0] sw_count_q, sw_count_d;
    logic [3:0] drain_q,    drain_d;
    logic       miss_q,     miss_d;

    always_comb begin
        sw_count_d = sw_count_q;
        drain_d    = drain_q;
        miss_d     = miss_q;
        if (enb) begin
            // Same edge that raises ack after a real switch.
            if (settle_done && busy_q && (sw_count_q != 8'hFF)) begin
                sw_count_d = sw_count_q + 8'd1;
            end
            if (state_q == DRAIN) begin
                if (drain_q != 4'hF) begin
                    drain_d = drain_q + 4'd1;
                end
                // drain_q counts DRAIN cycles already spent; reaching a ninth
                // one means the boundary strobe never arrived in time.
                if (drain_q >= DRAIN_MAX) begin
                    miss_d = 1'b1;
                end
            end else begin
                drain_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_count_q <= 8'd0;
            drain_q    <= 4'd0;
            miss_q     <= 1'b0;
        end else begin
            sw_count_q <= sw_count_d;
            drain_q    <= drain_d;
            miss_q     <= miss_d;
        end
    end

    assign sw_count = sw_count_q;
    assign stb_miss = miss_q;
`endif

endmodule
